// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS-subset CPU: one datapath phase per clock,
// memory ready handshake with timeout, retired-instruction counter and sticky illegal flag.
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             illegal_o
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              waiting;
  logic              retire;
  logic              funct_ok;

  assign timeout  = (wait_cnt == WAIT_LAST);
  assign funct_ok = funct_i inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  assign waiting  = (state inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem_ready_i;
  assign retire   = (state inside {S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB}) ||
                    ((state == S_MEMWR) && mem_ready_i);
  assign state_o  = state;

  // State, wait counter, retire counter and sticky illegal flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      retired_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (waiting && (state_nxt == state)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (retire) begin
        retired_o <= retired_o + CNT_W'(1);
      end
      if (state_nxt == S_TRAP) begin
        illegal_o <= 1'b1;
      end
    end
  end

  // Next state and Moore controls; FETCH load strobes are gated by ready
  always_comb begin
    state_nxt       = state;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    alu_op_o        = 2'd0;
    pc_source_o     = 2'd0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'd1;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_nxt  = S_DECODE;
          end else if (timeout) begin
            state_nxt = S_TRAP;
          end
        end
        S_DECODE: begin
          alu_src_b_o = 2'd3;
          case (op_i)
            OP_RTYPE:        state_nxt = funct_ok ? S_EXEC : S_TRAP;
            OP_LW, OP_SW:    state_nxt = S_MEMADR;
            OP_BEQ:          state_nxt = S_BRANCH;
            OP_J:            state_nxt = S_JUMP;
            OP_ADDI, OP_SLTI: state_nxt = S_IEXEC;
            default:         state_nxt = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
          if (op_i == OP_LW) begin
            state_nxt = S_MEMRD;
          end else if (op_i == OP_SW) begin
            state_nxt = S_MEMWR;
          end else begin
            state_nxt = S_TRAP;
          end
        end
        S_MEMRD: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
          if (mem_ready_i) begin
            state_nxt = S_MEMWB;
          end else if (timeout) begin
            state_nxt = S_TRAP;
          end
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          state_nxt    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
          if (mem_ready_i) begin
            state_nxt = S_FETCH;
          end else if (timeout) begin
            state_nxt = S_TRAP;
          end
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 2'd2;
          state_nxt   = S_RWB;
        end
        S_RWB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
          state_nxt   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = 2'd1;
          pc_write_cond_o = 1'b1;
          pc_source_o     = 2'd1;
          state_nxt       = S_FETCH;
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = 2'd2;
          state_nxt   = S_FETCH;
        end
        S_IEXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'd2;
          alu_op_o    = (op_i == OP_SLTI) ? 2'd3 : 2'd0;
          state_nxt   = S_IWB;
        end
        S_IWB: begin
          reg_write_o = 1'b1;
          state_nxt   = S_FETCH;
        end
        S_TRAP:  state_nxt = S_TRAP;
        default: state_nxt = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed, table-driven check of multi_cycle_ctrl sequencing, counters and traps.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd32;
  logic        rdy = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        illegal;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .mem_ready_i(rdy),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .i_or_d_o(i_or_d),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .state_o(state), .retired_o(retired), .illegal_o(illegal)
  );

  // ctrl order: pcw,pcwc,iord,mrd,mwr,irw,rdst,m2r,rw,srca | srcb | aluop | pcsrc
  localparam logic [15:0] C_0   = 16'd0;
  localparam logic [15:0] C_FR  = {10'b1001010000, 2'd1, 2'd0, 2'd0};
  localparam logic [15:0] C_FW  = {10'b0001000000, 2'd1, 2'd0, 2'd0};
  localparam logic [15:0] C_DE  = {10'b0000000000, 2'd3, 2'd0, 2'd0};
  localparam logic [15:0] C_MA  = {10'b0000000001, 2'd2, 2'd0, 2'd0};
  localparam logic [15:0] C_MR  = {10'b0011000000, 6'd0};
  localparam logic [15:0] C_MWB = {10'b0000000110, 6'd0};
  localparam logic [15:0] C_MW  = {10'b0010100000, 6'd0};
  localparam logic [15:0] C_EX  = {10'b0000000001, 2'd0, 2'd2, 2'd0};
  localparam logic [15:0] C_RWB = {10'b0000001010, 6'd0};
  localparam logic [15:0] C_BR  = {10'b0100000001, 2'd0, 2'd1, 2'd1};
  localparam logic [15:0] C_J   = {10'b1000000000, 2'd0, 2'd0, 2'd2};
  localparam logic [15:0] C_IE3 = {10'b0000000001, 2'd2, 2'd3, 2'd0};
  localparam logic [15:0] C_IWB = {10'b0000000010, 6'd0};

  typedef struct {
    logic        r;
    logic [5:0]  o;
    logic [5:0]  f;
    logic        rd;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] ret;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] ctrl_now();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // One cycle: drive at negedge, compare mid-low-phase, before the next rising edge
  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic rd,
                     input logic [3:0] st, input logic [15:0] ctl, input logic [31:0] ret,
                     input logic ill, input string tag);
    @(negedge clk);
    rst = r; op = o; funct = f; rdy = rd;
    #2;
    chk({tag, " state"}, 32'(state), 32'(st));
    chk({tag, " ctrl"}, 32'(ctrl_now()), 32'(ctl));
    chk({tag, " retired"}, retired, ret);
    chk({tag, " illegal"}, 32'(illegal), 32'(ill));
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic rd,
                     input logic [3:0] st, input logic [15:0] ctl, input logic [31:0] ret,
                     input logic ill);
    vec_t v;
    v.r = r; v.o = o; v.f = f; v.rd = rd; v.st = st; v.ctl = ctl; v.ret = ret; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    // reset, 3 cycles, ready high
    for (int i = 0; i < 3; i++) add(1, 0, 32, 1, 0, C_0, 0, 0);
    // add
    add(0, 0, 32, 1, 0, C_FR, 0, 0);   add(0, 0, 32, 1, 1, C_DE, 0, 0);
    add(0, 0, 32, 1, 6, C_EX, 0, 0);   add(0, 0, 32, 1, 7, C_RWB, 0, 0);
    // lw with three wait cycles in MEMRD
    add(0, 35, 0, 1, 0, C_FR, 1, 0);   add(0, 35, 0, 1, 1, C_DE, 1, 0);
    add(0, 35, 0, 1, 2, C_MA, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 35, 0, 0, 3, C_MR, 1, 0);
    add(0, 35, 0, 1, 3, C_MR, 1, 0);   add(0, 35, 0, 1, 4, C_MWB, 1, 0);
    // beq then j
    add(0, 4, 0, 1, 0, C_FR, 2, 0);    add(0, 4, 0, 1, 1, C_DE, 2, 0);
    add(0, 4, 0, 1, 8, C_BR, 2, 0);
    add(0, 2, 0, 1, 0, C_FR, 3, 0);    add(0, 2, 0, 1, 1, C_DE, 3, 0);
    add(0, 2, 0, 1, 9, C_J, 3, 0);
    // sw with one wait cycle
    add(0, 43, 0, 1, 0, C_FR, 4, 0);   add(0, 43, 0, 1, 1, C_DE, 4, 0);
    add(0, 43, 0, 1, 2, C_MA, 4, 0);   add(0, 43, 0, 0, 5, C_MW, 4, 0);
    add(0, 43, 0, 1, 5, C_MW, 4, 0);
    // addi, slti
    add(0, 8, 0, 1, 0, C_FR, 5, 0);    add(0, 8, 0, 1, 1, C_DE, 5, 0);
    add(0, 8, 0, 1, 10, C_MA, 5, 0);   add(0, 8, 0, 1, 11, C_IWB, 5, 0);
    add(0, 10, 0, 1, 0, C_FR, 6, 0);   add(0, 10, 0, 1, 1, C_DE, 6, 0);
    add(0, 10, 0, 1, 10, C_IE3, 6, 0); add(0, 10, 0, 1, 11, C_IWB, 6, 0);
    // R-type with illegal funct traps, then reset clears
    add(0, 0, 63, 1, 0, C_FR, 7, 0);   add(0, 0, 63, 1, 1, C_DE, 7, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 63, 1, 15, C_0, 7, 1);
    add(1, 0, 32, 1, 15, C_0, 7, 1);   add(1, 0, 32, 1, 0, C_0, 0, 0);

    foreach (vecs[i])
      cyc(vecs[i].r, vecs[i].o, vecs[i].f, vecs[i].rd, vecs[i].st, vecs[i].ctl,
          vecs[i].ret, vecs[i].ill, $sformatf("vec%0d", i));

    // illegal opcode 63: trap holds 20 cycles regardless of ready, reset clears
    cyc(0, 63, 0, 1, 0, C_FR, 0, 0, "op63 fetch");
    cyc(0, 63, 0, 1, 1, C_DE, 0, 0, "op63 decode");
    for (int i = 0; i < 20; i++)
      cyc(0, 63, 0, 1'(i % 2), 15, C_0, 0, 1, $sformatf("op63 trap%0d", i));
    cyc(1, 0, 32, 1, 15, C_0, 0, 1, "op63 rst");
    cyc(1, 0, 32, 1, 0, C_0, 0, 0, "op63 cleared");

    // reset in RWB aborts: no write strobe, no retire
    cyc(0, 0, 34, 1, 0, C_FR, 0, 0, "abort fetch");
    cyc(0, 0, 34, 1, 1, C_DE, 0, 0, "abort decode");
    cyc(0, 0, 34, 1, 6, C_EX, 0, 0, "abort exec");
    cyc(1, 0, 34, 1, 7, C_0, 0, 0, "abort rwb");
    cyc(0, 0, 34, 1, 0, C_FR, 0, 0, "abort after");

    // FETCH timeout: 15 waiting cycles then TRAP
    cyc(1, 0, 32, 0, 1, C_0, 0, 0, "to rst");
    for (int i = 0; i < 15; i++)
      cyc(0, 0, 32, 0, 0, C_FW, 0, 0, $sformatf("to wait%0d", i));
    cyc(0, 0, 32, 0, 15, C_0, 0, 1, "to trap");
    cyc(1, 35, 0, 0, 15, C_0, 0, 1, "to rst2");

    // ready on the 15th wait cycle wins; then MEMRD timeout
    for (int i = 0; i < 14; i++)
      cyc(0, 35, 0, 0, 0, C_FW, 0, 0, $sformatf("rw wait%0d", i));
    cyc(0, 35, 0, 1, 0, C_FR, 0, 0, "rw ready15");
    cyc(0, 35, 0, 0, 1, C_DE, 0, 0, "rw decode");
    cyc(0, 35, 0, 0, 2, C_MA, 0, 0, "rw memadr");
    for (int i = 0; i < 15; i++)
      cyc(0, 35, 0, 0, 3, C_MR, 0, 0, $sformatf("rd wait%0d", i));
    cyc(0, 35, 0, 0, 15, C_0, 0, 1, "rd trap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
